// File: rtl/idu_imm_stage_pkg.sv
// Shared decode types for the immediate-extract stage: opcode constants, the
// immediate format tag, the FSM state type and the stored decoded-entry record.
package idu_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_kind_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic [19:0] imm20;
    imm_kind_e   kind;
`ifdef IDU_ILLEGAL_DETECT_EN
    logic        illegal;
`endif
  } dec_t;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_IMM)    || (op == OP_IMM32) ||
           (op == OP_JALR)  || (op == OP_SYSTEM) || (op == OP_STORE) ||
           (op == OP_BRANCH)|| (op == OP_LUI)    || (op == OP_AUIPC) ||
           (op == OP_JAL)   || (op == OP_REG)    || (op == OP_REG32);
  endfunction

endpackage

// File: rtl/idu_imm_stage_if.sv
// Fetch-side and execute-side buses of the immediate-extract stage.
// out_illegal exists only when IDU_ILLEGAL_DETECT_EN is defined.
interface idu_imm_stage_if #(parameter int ADDR_W = 64);

  // A beat transfers on any rising clk where valid & ready are both 1; a
  // producer holds valid and its payload stable until that beat happens.
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [ADDR_W-1:0] in_pc;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [6:0]        out_opcode;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [2:0]        out_funct3;
  logic [6:0]        out_funct7;
  logic [11:0]       out_imm12;
  logic [19:0]       out_imm20;
  logic [2:0]        out_imm_kind;
`ifdef IDU_ILLEGAL_DETECT_EN
  logic              out_illegal;
`endif

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
`ifdef IDU_ILLEGAL_DETECT_EN
    output out_illegal,
`endif
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm12, out_imm20, out_imm_kind
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
`ifdef IDU_ILLEGAL_DETECT_EN
    input  out_illegal,
`endif
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm12, out_imm20, out_imm_kind
  );

endinterface

// File: rtl/idu_imm_extract.sv
// Combinational decode of one instruction into the stored entry record.
// Optional illegal-opcode flag under IDU_ILLEGAL_DETECT_EN.
module idu_imm_extract
  import idu_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  always_comb begin
    dec        = '0;
    dec.opcode = inst[6:0];
    dec.rd     = inst[11:7];
    dec.rs1    = inst[19:15];
    dec.rs2    = inst[24:20];
    dec.funct3 = inst[14:12];
    dec.funct7 = inst[31:25];
    dec.kind   = IMM_NONE;

    // B and J fields carry offset>>1; execute restores bit 0 after extension.
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
        dec.imm12 = inst[31:20];
        dec.kind  = IMM_I;
      end
      OP_STORE: begin
        dec.imm12 = {inst[31:25], inst[11:7]};
        dec.kind  = IMM_S;
      end
      OP_BRANCH: begin
        dec.imm12 = {inst[31], inst[7], inst[30:25], inst[11:8]};
        dec.kind  = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec.imm20 = inst[31:12];
        dec.kind  = IMM_U;
      end
      OP_JAL: begin
        dec.imm20 = {inst[31], inst[19:12], inst[20], inst[30:21]};
        dec.kind  = IMM_J;
      end
      default: ;
    endcase

`ifdef IDU_ILLEGAL_DETECT_EN
    dec.illegal = (inst[1:0] != 2'b11) || !is_known_op(inst[6:0]);
`endif
  end

endmodule

// File: rtl/idu_imm_stage.sv
// Decode stage ahead of the 12-bit sign-extender: 2-entry skid buffer of
// decoded entries. IDU_ILLEGAL_DETECT_EN adds a per-entry out_illegal flag.
module idu_imm_stage
  import idu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  idu_imm_stage_if.slave        io,
  output state_e                dbg_state
);

  dec_t              in_dec;
  state_e            state_q, state_d;
  dec_t              head_q, head_d, tail_q, tail_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic              push, pop;

  idu_imm_extract u_extract (
    .inst (io.in_inst),
    .dec  (in_dec)
  );

  assign io.in_ready  = (state_q != ST_TWO);
  assign io.out_valid = (state_q != ST_EMPTY);
  assign push = io.in_valid  & io.in_ready  & ~flush;
  assign pop  = io.out_valid & io.out_ready & ~flush;

  // Head always lives in the head slot; a pop from TWO shifts the tail forward.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    head_pc_d = head_pc_q;
    tail_d    = tail_q;
    tail_pc_d = tail_pc_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d    = in_dec;
          head_pc_d = io.in_pc;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d    = in_dec;
          head_pc_d = io.in_pc;
        end else if (push) begin
          tail_d    = in_dec;
          tail_pc_d = io.in_pc;
          state_d   = ST_TWO;
        end else if (pop) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d    = tail_q;
          head_pc_d = tail_pc_q;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      head_q    <= '0;
      head_pc_q <= '0;
      tail_q    <= '0;
      tail_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      head_pc_q <= head_pc_d;
      tail_q    <= tail_d;
      tail_pc_q <= tail_pc_d;
    end
  end

  assign io.out_pc       = head_pc_q;
  assign io.out_opcode   = head_q.opcode;
  assign io.out_rd       = head_q.rd;
  assign io.out_rs1      = head_q.rs1;
  assign io.out_rs2      = head_q.rs2;
  assign io.out_funct3   = head_q.funct3;
  assign io.out_funct7   = head_q.funct7;
  assign io.out_imm12    = head_q.imm12;
  assign io.out_imm20    = head_q.imm20;
  assign io.out_imm_kind = head_q.kind;
`ifdef IDU_ILLEGAL_DETECT_EN
  assign io.out_illegal  = head_q.illegal;
`endif
  assign dbg_state       = state_q;

endmodule
